// File: rtl/keccak_tvla_ctrl.sv
// keccak_tvla_ctrl: run sequencer for the two-share masked Keccak-f[1600] TVLA target.
module keccak_tvla_ctrl #(
  parameter int STATE_W = 1600,
  parameter int RND_W = 2,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [STATE_W-1:0]   din_share0_i,
  input  logic [STATE_W-1:0]   din_share1_i,
  input  logic [31:0]          seed_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 timeout_o,
  output logic                 trig_o,
  output logic [CNT_W-1:0]     cycles_o,
  output logic [2*STATE_W-1:0] result_o,
  output logic                 dut_rst_o,
  output logic [2*STATE_W-1:0] dut_din_o,
  output logic                 dut_din_vld_o,
  output logic [RND_W-1:0]     dut_r_o,
  output logic                 dut_r_vld_o,
  output logic                 dut_rst_vld_o,
  input  logic [2*STATE_W-1:0] dut_dout_i,
  input  logic                 dut_dout_vld_i
);
  typedef enum logic [2:0] {IDLE, RESET, LOAD, RUN, ABORT} state_t;
  state_t state_q, state_d;
  logic ph_q, ph_d, go;
  logic [31:0] lfsr_q, lfsr_d, lfsr_nx;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, cycles_q, cycles_d;
  logic done_q, done_d, tmo_q, tmo_d, trig_q, trig_d, dinv_q, dinv_d, rv_q, rv_d;
  logic [RND_W-1:0] r_q, r_d;
  logic [2*STATE_W-1:0] res_q, res_d, din_q, din_d;
  always_comb begin
    go = state_q == IDLE && start_i;
    lfsr_nx = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);
    cnt_inc = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
    state_d = state_q;
    ph_d = 1'b0;
    cnt_d = go ? '0 : state_q == RUN ? cnt_inc : cnt_q;
    din_d = go ? {din_share1_i, din_share0_i} : din_q;
    res_d = res_q;
    cycles_d = cycles_q;
    done_d = 1'b0;
    tmo_d = go ? 1'b0 : tmo_q;
    case (state_q)
      IDLE: state_d = start_i ? RESET : IDLE;
      RESET, ABORT: begin
        ph_d = ~ph_q;
        if (ph_q) state_d = state_q == RESET ? LOAD : IDLE;
      end
      LOAD: state_d = RUN;
      RUN: begin
        if (dut_dout_vld_i) begin
          state_d = IDLE;
          res_d = dut_dout_i;
          cycles_d = cnt_inc;
          done_d = 1'b1;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          state_d = ABORT;
          tmo_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Strobes are registered from the next state so they align with the state they belong to
    dinv_d = state_d == LOAD;
    trig_d = state_d == LOAD || state_d == RUN;
    rv_d = state_d == RUN;
    r_d = rv_d ? lfsr_q[RND_W-1:0] : '0;
    lfsr_d = go ? (seed_i == '0 ? 32'h1 : seed_i) : rv_d ? lfsr_nx : lfsr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ph_q <= 1'b0;
      lfsr_q <= 32'h1;
      cnt_q <= '0;
      cycles_q <= '0;
      done_q <= 1'b0;
      tmo_q <= 1'b0;
      trig_q <= 1'b0;
      dinv_q <= 1'b0;
      rv_q <= 1'b0;
      r_q <= '0;
      res_q <= '0;
      din_q <= '0;
    end else begin
      state_q <= state_d;
      ph_q <= ph_d;
      lfsr_q <= lfsr_d;
      cnt_q <= cnt_d;
      cycles_q <= cycles_d;
      done_q <= done_d;
      tmo_q <= tmo_d;
      trig_q <= trig_d;
      dinv_q <= dinv_d;
      rv_q <= rv_d;
      r_q <= r_d;
      res_q <= res_d;
      din_q <= din_d;
    end
  end
  assign busy_o = state_q != IDLE;
  assign done_o = done_q;
  assign timeout_o = tmo_q;
  assign trig_o = trig_q;
  assign cycles_o = cycles_q;
  assign result_o = res_q;
  assign dut_rst_o = rst || state_q == RESET || state_q == ABORT;
  assign dut_rst_vld_o = dut_rst_o;
  assign dut_din_o = din_q;
  assign dut_din_vld_o = dinv_q;
  assign dut_r_o = r_q;
  assign dut_r_vld_o = rv_q;
endmodule
